// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase control FSM for the 8-bit RISC CPU (fetch, decode, operand, execute/store).
// Optional macro SEQ_SINGLE_STEP_EN adds a `step` input that gates the start of each instruction.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);

    localparam int unsigned PHASE_W = 3;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               halted_q, halted_d;
    logic               advance;
    logic               alu_op;
    logic               is_sto;
    logic               is_jmp;
    logic               is_hlt;
    logic               is_skz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next state: HLT in OP_ADDR latches halted and freezes the phase until reset.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        advance  = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        if (phase_q == PH_INST_ADDR && !step) begin
            advance = 1'b0;
        end
`endif
        if (!halted_q) begin
            if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (advance) begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign is_hlt = (opcode == OP_HLT);
    assign is_skz = (opcode == OP_SKZ);

    // Output decode; data_e leads wr by one phase so the bus is stable at the write edge.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = alu_op;
                end
                PH_ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, hand-written corner sequences,
// and randomized stimulus checked against a phase-counter reference model (honours SEQ_SINGLE_STEP_EN).
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [8:0] outs;

    // Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    cpu_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef SEQ_SINGLE_STEP_EN
        .step   (step),
`endif
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] opcode;
        logic       zero;
        int         phase;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_ph     = 0;
    bit   m_halt   = 1'b0;

    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_SEL   = 9'b100000000;
    localparam logic [8:0] O_RD    = 9'b010000000;
    localparam logic [8:0] O_LDIR  = 9'b001000000;
    localparam logic [8:0] O_INC   = 9'b000100000;
    localparam logic [8:0] O_LDPC  = 9'b000010000;
    localparam logic [8:0] O_LDAC  = 9'b000001000;
    localparam logic [8:0] O_WR    = 9'b000000100;
    localparam logic [8:0] O_DATAE = 9'b000000010;
    localparam logic [8:0] O_HALT  = 9'b000000001;

    // Reference outputs written directly from the per-phase rule list.
    function automatic logic [8:0] model_out(int ph, bit h, logic [2:0] op, logic z);
        bit aluop;
        logic [8:0] o;
        if (h) return O_HALT;
        aluop = (op >= 3'd2) && (op <= 3'd5);
        o = O_NONE;
        if (ph <= 3)                          o |= O_SEL;
        if ((ph >= 1 && ph <= 3) || (ph >= 5 && aluop)) o |= O_RD;
        if (ph == 2 || ph == 3)               o |= O_LDIR;
        if (ph == 4 || (ph == 6 && op == 3'd1 && z)) o |= O_INC;
        if (ph >= 6 && op == 3'd7)            o |= O_LDPC;
        if (ph == 7 && aluop)                 o |= O_LDAC;
        if (ph == 7 && op == 3'd6)            o |= O_WR;
        if (ph >= 6 && op == 3'd6)            o |= O_DATAE;
        if (ph == 4 && op == 3'd0)            o |= O_HALT;
        return o;
    endfunction

    // Model state update at a rising edge with rst_n high.
    function automatic void model_edge();
        bit go;
        go = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        if (m_ph == 0 && !step) go = 1'b0;
`endif
        if (m_halt) return;
        if (m_ph == 4 && opcode == 3'd0) m_halt = 1'b1;
        else if (go) m_ph = (m_ph + 1) % 8;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got outs=%b expected %b (model phase %0d halted %0d) at %0t",
                     name, act, exp, m_ph, m_halt, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle_check(input string name, input logic [8:0] exp);
        @(negedge clk);
        if (!rst_n) begin
            m_ph = 0;
            m_halt = 1'b0;
        end
        check(name, outs, exp);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic cycle_model(input string name);
        @(negedge clk);
        if (!rst_n) begin
            m_ph = 0;
            m_halt = 1'b0;
        end
        check(name, outs, model_out(m_ph, m_halt, opcode, zero));
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic add_instr(input logic [2:0] op, input logic z,
                             input logic [8:0] t5, input logic [8:0] t6, input logic [8:0] t7);
        logic [8:0] e[8];
        e[0] = O_SEL;
        e[1] = O_SEL | O_RD;
        e[2] = O_SEL | O_RD | O_LDIR;
        e[3] = O_SEL | O_RD | O_LDIR;
        e[4] = O_INC;
        e[5] = t5;
        e[6] = t6;
        e[7] = t7;
        for (int p = 0; p < 8; p++) vecs.push_back('{opcode: op, zero: z, phase: p, exp: e[p]});
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step   = 1'b1;
`endif
        // Directed table: one full instruction per opcode of interest.
        add_instr(3'd2, 1'b0, O_RD, O_RD, O_RD | O_LDAC);
        add_instr(3'd6, 1'b0, O_NONE, O_DATAE, O_WR | O_DATAE);
        add_instr(3'd1, 1'b1, O_NONE, O_INC, O_NONE);
        add_instr(3'd1, 1'b0, O_NONE, O_NONE, O_NONE);
        add_instr(3'd7, 1'b0, O_NONE, O_LDPC, O_LDPC);
        add_instr(3'd5, 1'b1, O_RD, O_RD, O_RD | O_LDAC);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs, O_SEL);
        rst_n = 1'b1;
        m_ph = 0;
        m_halt = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].opcode;
            zero   = vecs[i].zero;
            cycle_check($sformatf("tbl_op%0d_z%0d_ph%0d", vecs[i].opcode, vecs[i].zero, vecs[i].phase),
                        vecs[i].exp);
        end

        // HLT: halt rises in phase 4, then only halt stays asserted until reset.
        opcode = 3'd0;
        zero   = 1'b1;
        for (int p = 0; p < 4; p++) cycle_model("hlt_pre");
        cycle_check("hlt_ph4", O_INC | O_HALT);
        for (int c = 0; c < 20; c++) begin
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom);
            cycle_check("hlt_hold", O_HALT);
        end
        rst_n = 1'b0;
        #1;
        check("hlt_rst_async", outs, O_SEL);
        m_ph = 0;
        m_halt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // STO with reset asserted in phase 7: wr must drop without a clock edge.
        opcode = 3'd6;
        zero   = 1'b0;
        for (int p = 0; p < 7; p++) cycle_model("sto_pre");
        #2;
        check("sto_ph7_wr", outs, O_WR | O_DATAE);
        rst_n = 1'b0;
        #1;
        check("sto_rst_async", outs, O_SEL);
        m_ph = 0;
        m_halt = 1'b0;
        @(posedge clk);
        #1;
        check("sto_rst_hold", outs, O_SEL);
        rst_n = 1'b1;
        opcode = 3'd2;
        cycle_check("release_ph0", O_SEL);
        cycle_check("release_ph1", O_SEL | O_RD);

        // Randomized run against the reference model, with occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom);
            rst_n  = ($urandom_range(0, 39) != 0);
`ifdef SEQ_SINGLE_STEP_EN
            step   = ($urandom_range(0, 3) != 0);
`endif
            cycle_model("rand");
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: hold in phase 0, one pulse runs exactly one instruction.
        rst_n = 1'b0;
        step  = 1'b0;
        opcode = 3'd2;
        @(posedge clk);
        #1;
        m_ph = 0;
        m_halt = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) cycle_check("step_hold", O_SEL);
        step = 1'b1;
        cycle_check("step_ph0", O_SEL);
        step = 1'b0;
        cycle_check("step_ph1", O_SEL | O_RD);
        for (int p = 2; p < 8; p++) cycle_model("step_run");
        for (int c = 0; c < 4; c++) cycle_check("step_after", O_SEL);
`else
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

- Eight-phase control state machine for the 8-bit RISC CPU. It sits directly upstream of the 32-byte unified memory and drives its `write_en` (through `wr`) and, through `sel`, the address-source mux.
- Each instruction takes eight clock cycles: fetch, decode, operand access and execute/store.
- It decodes the 3-bit opcode from the instruction register and sequences PC, IR, accumulator and bus-driver loads.

## Interface
Parameters:
- none; phase count (8) and opcode width (3) are fixed by the ISA.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  3  IR[7:5]; valid from phase 4 onward.
- `zero`  in  1  accumulator-zero flag.
- `sel`  out  1  address mux: 1 = PC, 0 = IR[4:0].
- `rd`  out  1  memory read phase (drives CPU data path toward memory output).
- `ld_ir`  out  1  load instruction register.
- `inc_pc`  out  1  increment PC.
- `ld_pc`  out  1  load PC from IR[4:0].
- `ld_ac`  out  1  load accumulator from ALU.
- `wr`  out  1  memory write enable (to memory `write_en`).
- `data_e`  out  1  enable accumulator tri-state driver onto shared data bus.
- `halt`  out  1  CPU halted.

## Operation
- 3-bit `phase` register, plus a `halted` flag.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- Outputs are a Moore/Mealy decode of `phase`, `opcode` and `zero`. Every output not listed for a phase is 0.
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- `phase` increments by 1 each cycle and wraps 7 -> 0.
- HLT:
  - In phase 4 with opcode=HLT, `halted` sets on that edge and `phase` freezes at 4.
  - While halted, only halt=1 is asserted: inc_pc=0 and all other outputs 0. PC stops.
  - Only `rst_n` low leaves the halted state.
- `data_e` covers phases 6-7 of STO. `wr` is only phase 7, so the bus is driven one cycle before and during the memory write edge.
- SKZ with zero=0 and HLT are no-ops in phases 5-7, apart from the halt behaviour above.
- `opcode`/`zero` are ignored in phases 0-3.

## Timing
- Reset (rst_n=0, async): phase=0 and halted=0 immediately. Outputs: sel=1, all others 0.
- Release is synchronous in effect: the first rising edge with rst_n=1 moves phase 0 -> 1.
- Reset asserted mid-instruction (any phase, including a STO phase 7 or halted): outputs collapse to phase-0 values the same delta. No partial write completes after reset assertion.
- Outputs are combinational from registered state; there is zero-cycle latency from a phase change to its outputs.
- Memory reads have 1-cycle latency. Address from PC is stable from phase 0, so the instruction byte is on the bus by phase 2 and IR captures it at the end of phase 3.
- The instruction period is exactly 8 cycles. PC advances once in phase 4, plus once more in phase 6 on a taken SKZ.
- JMP: ld_pc is held for 2 cycles (phases 6-7). Reloading the same target is idempotent.

## Configuration
- Macro `SEQ_SINGLE_STEP_EN`.
- Defined:
  - Adds input `step` (1 bit).
  - Phase 0 advances to 1 only on an edge where step=1; otherwise it holds in phase 0 with sel=1 only.
  - Exactly one instruction executes per step pulse.
  - step is ignored in phases 1-7 and while halted.
  - A step held high runs continuously.
- Undefined: no `step` port; phase 0 always advances.

## Test plan
- Reset, then release with opcode=2 (ADD): sel=1 in phases 0-3; rd=1 in phases 1-3 and 5-7; ld_ir=1 in phases 2-3; inc_pc=1 in phase 4 only; ld_ac=1 in phase 7 only; phase returns to 0 at cycle 8.
- opcode=6 (STO): data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 and ld_ac=0 in phases 5-7.
- opcode=1 (SKZ):
  - zero=1: inc_pc=1 in phases 4 and 6.
  - zero=0: inc_pc=1 only in phase 4.
- opcode=0 (HLT): halt=1 from phase 4. Holding 20 cycles keeps phase=4, inc_pc=0, wr=0. Pulsing rst_n low then high gives phase 0 and halt=0.
- opcode=7 (JMP): ld_pc=1 in phases 6-7, wr=0 and ld_ac=0 throughout. Asserting rst_n low during phase 7 of a STO drops wr to 0 asynchronously.
- With `SEQ_SINGLE_STEP_EN`: step=0 holds phase 0 for 10 cycles. A 1-cycle step pulse runs exactly one 8-cycle instruction, then the block holds in phase 0 again.
